// File: rtl/lut_share_scheduler.sv
// rtl/lut_share_scheduler.sv - round-robin time-multiplexer for one shared neuron LUT
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_data    per-requester request; requester i at req_data[i*IN_W +: IN_W]
//   req_ready             one-hot accept strobe (IDLE only)
//   lut_in / lut_out      registered LUT input vector / shared LUT result
//   rsp_valid/data/id     captured result and owning requester, held until rsp_ready
//   busy                  high whenever an evaluation or response is outstanding
module lut_share_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = 8,
  parameter int OUT_W   = 2,
  parameter int LUT_LAT = 0,
  localparam int ID_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [IN_W-1:0]         lut_in,
  input  logic [OUT_W-1:0]        lut_out,
  output logic                    rsp_valid,
  output logic [OUT_W-1:0]        rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  input  logic                    rsp_ready,
  output logic                    busy
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IN_W-1:0]   lut_in_q, lut_in_d;
  logic [OUT_W-1:0]  rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic [IN_W-1:0]   grant_data;

  // Round-robin search in two passes: first requesters at or above ptr,
  // then the wrapped-around ones below it.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    grant_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && (ID_W'(i) >= ptr_q) && req_valid[i]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_found && (grant_id == ID_W'(i))) begin
        grant_data = req_data[i*IN_W +: IN_W];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      lut_in_q    <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      lut_in_q    <= lut_in_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    lut_in_d    = lut_in_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      S_IDLE: begin
        // req_ready is asserted exactly at grant_id, so a found grant is a handshake.
        if (grant_found) begin
          lut_in_d = grant_data;
          rsp_id_d = grant_id;
          ptr_d    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          cnt_d    = CNT_W'(LUT_LAT);
          state_d  = S_EVAL;
        end
      end
      S_EVAL: begin
        // Wait out the LUT pipeline; capture on the cycle the count reaches zero.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rsp_data_d  = lut_out;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = '0;
    if ((state_q == S_IDLE) && !rst && grant_found) begin
      req_ready[grant_id] = 1'b1;
    end
    busy = (state_q != S_IDLE);
  end

  assign lut_in    = lut_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_lut_share_scheduler.sv
// tb/tb_lut_share_scheduler.sv - directed self-checking bench for lut_share_scheduler
module tb_lut_share_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = 4'b0000;
  logic [3:0]  req_valid3 = 4'b0000;
  logic [31:0] req_data = '0;
  logic        rsp_ready = 1'b0;

  logic [3:0]  req_ready0, req_ready3;
  logic [7:0]  lut_in0, lut_in3;
  logic [1:0]  lut_out0, lut_out3;
  logic        rsp_valid0, rsp_valid3;
  logic [1:0]  rsp_data0, rsp_data3;
  logic [1:0]  rsp_id0, rsp_id3;
  logic        busy0, busy3;
  logic [1:0]  lcnt = 2'b00;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Combinational LUT for the zero-latency instance; free-running value for the LUT_LAT=3 one.
  assign lut_out0 = lut_in0[5:4];
  assign lut_out3 = lcnt;
  always @(posedge clk) lcnt <= lcnt + 2'd1;

  lut_share_scheduler #(.NUM_REQ(4), .IN_W(8), .OUT_W(2), .LUT_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready0), .lut_in(lut_in0), .lut_out(lut_out0),
    .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .rsp_id(rsp_id0),
    .rsp_ready(rsp_ready), .busy(busy0)
  );

  lut_share_scheduler #(.NUM_REQ(4), .IN_W(8), .OUT_W(2), .LUT_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_data(req_data),
    .req_ready(req_ready3), .lut_in(lut_in3), .lut_out(lut_out3),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .rsp_id(rsp_id3),
    .rsp_ready(rsp_ready), .busy(busy3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    req_valid3 = 4'b1111;
    #1;
    checks++; if (req_ready0 !== 4'b0000) begin errors++; $display("FAIL reset_req_ready0: got %b expected 0000", req_ready0); end
    checks++; if (req_ready3 !== 4'b0000) begin errors++; $display("FAIL reset_req_ready3: got %b expected 0000", req_ready3); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid0); end
    checks++; if (lut_in0 !== 8'h00) begin errors++; $display("FAIL reset_lut_in: got %h expected 00", lut_in0); end
    checks++; if (rsp_id0 !== 2'd0 || rsp_data0 !== 2'd0) begin errors++; $display("FAIL reset_rsp_id_data: got id=%0d data=%0d expected 0 0", rsp_id0, rsp_data0); end
    tick();
    tick();
    req_valid = 4'b0000;
    req_valid3 = 4'b0000;
    rst = 1'b0;
  endtask

  task automatic test_single();
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready0 !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", req_ready0); end
    tick();
    req_valid = 4'b0000;
    checks++; if (busy0 !== 1'b1 || rsp_valid0 !== 1'b0) begin errors++; $display("FAIL single_eval: got busy=%b rsp_valid=%b expected 1 0", busy0, rsp_valid0); end
    checks++; if (lut_in0 !== 8'hA5) begin errors++; $display("FAIL single_lut_in: got %h expected a5", lut_in0); end
    tick();
    checks++; if (rsp_valid0 !== 1'b1 || rsp_data0 !== 2'b10 || rsp_id0 !== 2'd0) begin errors++; $display("FAIL single_rsp: got v=%b d=%b id=%0d expected 1 10 0", rsp_valid0, rsp_data0, rsp_id0); end
    tick();
    checks++; if (busy0 !== 1'b0 || rsp_valid0 !== 1'b0) begin errors++; $display("FAIL single_done: got busy=%b rsp_valid=%b expected 0 0", busy0, rsp_valid0); end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int k = 0;
    int rk = 0;
    int last = 0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(((3 - i) << 4) | i);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 40 && k < 5; c++) begin
      if (req_ready0 !== 4'b0000) begin
        checks++; if (req_ready0 !== 4'(1 << order[k])) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready0, 4'(1 << order[k])); end
        if (k > 0) begin
          checks++; if (c - last != 3) begin errors++; $display("FAIL rr_spacing%0d: got %0d expected 3", k, c - last); end
        end
        last = c;
        k++;
      end
      if (rsp_valid0 === 1'b1) begin
        checks++; if (rsp_id0 !== 2'(order[rk]) || rsp_data0 !== 2'(3 - order[rk])) begin errors++; $display("FAIL rr_rsp%0d: got id=%0d d=%0d expected id=%0d d=%0d", rk, rsp_id0, rsp_data0, order[rk], 3 - order[rk]); end
        rk++;
      end
      tick();
    end
    req_valid = 4'b0000;
    checks++; if (k != 5) begin errors++; $display("FAIL rr_timeout: got %0d grants expected 5", k); end
    tick();
    checks++; if (rsp_valid0 !== 1'b1 || rsp_id0 !== 2'd0 || rsp_data0 !== 2'd3) begin errors++; $display("FAIL rr_last_rsp: got v=%b id=%0d d=%0d expected 1 0 3", rsp_valid0, rsp_id0, rsp_data0); end
    tick();
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rr_idle: got busy=%b expected 0", busy0); end
  endtask

  task automatic test_hold();
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready0 !== 4'b0100) begin errors++; $display("FAIL hold_grant: got %b expected 0100", req_ready0); end
    tick();
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready0 !== 4'b0000) begin errors++; $display("FAIL hold_eval_ready: got %b expected 0000", req_ready0); end
    tick();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (rsp_valid0 !== 1'b1 || rsp_data0 !== 2'd1 || rsp_id0 !== 2'd2 || req_ready0 !== 4'b0000) begin
        errors++;
        $display("FAIL hold_cycle%0d: got v=%b d=%0d id=%0d ready=%b expected 1 1 2 0000", c, rsp_valid0, rsp_data0, rsp_id0, req_ready0);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL hold_release: got rsp_valid=%b expected 0", rsp_valid0); end
    checks++; if (req_ready0 !== 4'b1000) begin errors++; $display("FAIL hold_next_grant: got %b expected 1000", req_ready0); end
    req_valid = 4'b0000;
    #1;
  endtask

  task automatic test_wrap();
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready0 !== 4'b0010) begin errors++; $display("FAIL wrap_grant: got %b expected 0010", req_ready0); end
    tick();
    req_valid = 4'b0000;
    checks++; if (lut_in0 !== 8'h21 || rsp_id0 !== 2'd1) begin errors++; $display("FAIL wrap_capture: got lut_in=%h id=%0d expected 21 1", lut_in0, rsp_id0); end
    tick();
    tick();
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready0 !== 4'b0100) begin errors++; $display("FAIL wrap_ptr: got %b expected 0100", req_ready0); end
    req_valid = 4'b0000;
    #1;
  endtask

  task automatic test_reset_mid_eval();
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready0 !== 4'b0100) begin errors++; $display("FAIL rst_mid_grant: got %b expected 0100", req_ready0); end
    tick();
    req_valid = 4'b0000;
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL rst_mid_eval: got busy=%b expected 1", busy0); end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (busy0 !== 1'b0 || rsp_valid0 !== 1'b0 || lut_in0 !== 8'h00 || rsp_id0 !== 2'd0 || req_ready0 !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_async: got busy=%b v=%b lut_in=%h id=%0d ready=%b expected 0 0 00 0 0000", busy0, rsp_valid0, lut_in0, rsp_id0, req_ready0);
    end
    #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL rst_mid_no_rsp%0d: got %b expected 0", c, rsp_valid0); end
    end
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready0 !== 4'b0001) begin errors++; $display("FAIL rst_mid_ptr: got %b expected 0001", req_ready0); end
    req_valid = 4'b0000;
    #1;
  endtask

  task automatic test_latency3();
    logic [1:0] exp_data;
    exp_data = 2'd0;
    rsp_ready = 1'b1;
    req_valid3 = 4'b0001;
    #1;
    checks++; if (req_ready3 !== 4'b0001) begin errors++; $display("FAIL lat3_grant: got %b expected 0001", req_ready3); end
    tick();
    req_valid3 = 4'b0000;
    checks++; if (lut_in3 !== 8'h30) begin errors++; $display("FAIL lat3_lut_in: got %h expected 30", lut_in3); end
    for (int c = 1; c <= 4; c++) begin
      checks++; if (busy3 !== 1'b1 || rsp_valid3 !== 1'b0) begin errors++; $display("FAIL lat3_eval%0d: got busy=%b v=%b expected 1 0", c, busy3, rsp_valid3); end
      if (c == 4) exp_data = lut_out3;
      tick();
    end
    checks++; if (rsp_valid3 !== 1'b1 || rsp_data3 !== exp_data || rsp_id3 !== 2'd0) begin errors++; $display("FAIL lat3_rsp: got v=%b d=%0d id=%0d expected 1 %0d 0", rsp_valid3, rsp_data3, rsp_id3, exp_data); end
    tick();
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL lat3_idle: got busy=%b expected 0", busy3); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_wrap();
    test_reset_mid_eval();
    test_latency3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
